// File: rtl/tp_ntt_pkg.sv
// Shared opcodes, loader states and twiddle-part helper
// for the TP-NTT host-side loader.
package tp_ntt_pkg;

  localparam logic [1:0] OP_IDLE    = 2'd0;
  localparam logic [1:0] OP_TWIDDLE = 2'd1;
  localparam logic [1:0] OP_START   = 2'd2;
  localparam logic [1:0] OP_QLOAD   = 2'd3;

  localparam int Q_HOLD_CYC = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_Q_ISSUE,
    ST_Q_HOLD,
    ST_TW_ISSUE,
    ST_TW_STREAM,
    ST_PREFILL,
    ST_ST_ISSUE,
    ST_STREAM
  } ld_state_t;

  function automatic int parts_of(
    input int iter_choice
  );
    unique case (iter_choice)
      0:       return 2;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

endpackage

// File: rtl/tp_ntt_stream_fifo.sv
// Synchronous coefficient FIFO (push/pop/full/empty/count).
// Ports: clk, rst, push, wdata, pop, rdata(head), full, empty, count.
module tp_ntt_stream_fifo #(
  parameter  int W     = 256,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // a pop frees the slot the same cycle
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push)
                     - CW'(do_pop);
    end
  end

endmodule

// File: rtl/tp_ntt_loader.sv
// Host-side sequencer driving one TP-NTT block's fixed-timing port.
// Ports: cmd/tw/in valid-ready streams in; OP/Q/TWIDDLE/DATA to block;
// underrun, busy. Define TP_NTT_LOADER_CHECK_EN for cmd_err ordering.
module tp_ntt_loader
  import tp_ntt_pkg::*;
#(
  parameter int N           = 128,
  parameter int TP          = 8,
  parameter int LOGQ        = 32,
  parameter int ITER_CHOICE = 1,
  parameter int FIFO_DEPTH  = 16,
  parameter int PREFILL     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [LOGQ-1:0]        cmd_q,
  input  logic                   tw_valid,
  output logic                   tw_ready,
  input  logic [(TP-1)*LOGQ-1:0] tw_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TP*LOGQ-1:0]     in_data,
  output logic [1:0]             OP_TYPE_OUT,
  output logic                   START_OUT,
  output logic [LOGQ-1:0]        Q_OUT,
  output logic [(TP-1)*LOGQ-1:0] TWIDDLE_OUT,
  output logic [TP*LOGQ-1:0]     NTT_DATA_OUT,
  output logic                   underrun,
  output logic                   busy
`ifdef TP_NTT_LOADER_CHECK_EN
  ,
  output logic                   cmd_err
`endif
);

  localparam int PARTS = parts_of(ITER_CHOICE);
  localparam int TOTAL = PARTS * (N / TP);
  localparam int CNTW  = $clog2(TOTAL) + 1;
  localparam int DW    = TP * LOGQ;
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  ld_state_t       state, state_d;
  logic [CNTW-1:0] cnt, cnt_d;
  logic [1:0]      op_d;
  logic [LOGQ-1:0] q_d;
  logic [DW-1:0]   data_d;
  logic            und_d;
  logic            start_ok;

  logic            f_push;
  logic            f_pop;
  logic [DW-1:0]   f_rdata;
  logic            f_full;
  logic            f_empty;
  logic [FCW-1:0]  f_count;
  logic            strm;

  assign strm = (state == ST_ST_ISSUE)
             || (state == ST_STREAM);

  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign tw_ready  = (state == ST_TW_STREAM);
  assign busy      = (state != ST_IDLE);
  assign START_OUT = 1'b0;
  assign in_ready  = strm
    || ((state == ST_PREFILL) && !f_full);

  // twiddle beats pass straight through so the
  // beat handshaked in a cycle is the one shown
  assign TWIDDLE_OUT =
    (tw_ready && tw_valid) ? tw_data : '0;

  assign f_push = in_valid && in_ready;
  assign f_pop  = strm;

  tp_ntt_stream_fifo #(
    .W     (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (f_push),
    .wdata (in_data),
    .pop   (f_pop),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    op_d    = OP_IDLE;
    q_d     = Q_OUT;
    data_d  = '0;
    und_d   = underrun;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_QLOAD: begin
              state_d = ST_Q_ISSUE;
              op_d    = OP_QLOAD;
              q_d     = cmd_q;
            end
            OP_TWIDDLE: begin
              state_d = ST_TW_ISSUE;
              op_d    = OP_TWIDDLE;
            end
            OP_START: begin
              if (start_ok) begin
                state_d = ST_PREFILL;
              end
            end
            default: ;
          endcase
        end
      end
      ST_Q_ISSUE: begin
        state_d = ST_Q_HOLD;
        cnt_d   = '0;
      end
      ST_Q_HOLD: begin
        if (cnt == CNTW'(Q_HOLD_CYC - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt + CNTW'(1);
        end
      end
      ST_TW_ISSUE: begin
        state_d = ST_TW_STREAM;
        cnt_d   = '0;
      end
      ST_TW_STREAM: begin
        if (!tw_valid) begin
          und_d = 1'b1;
        end
        if (cnt == CNTW'(TOTAL - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt + CNTW'(1);
        end
      end
      ST_PREFILL: begin
        if (f_count >= FCW'(PREFILL)) begin
          state_d = ST_ST_ISSUE;
          op_d    = OP_START;
        end
      end
      ST_ST_ISSUE,
      ST_STREAM: begin
        state_d = ST_STREAM;
        if (!f_empty) begin
          data_d = f_rdata;
        end else begin
          und_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      OP_TYPE_OUT  <= OP_IDLE;
      Q_OUT        <= '0;
      NTT_DATA_OUT <= '0;
      underrun     <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      OP_TYPE_OUT  <= op_d;
      Q_OUT        <= q_d;
      NTT_DATA_OUT <= data_d;
      underrun     <= und_d;
    end
  end

`ifdef TP_NTT_LOADER_CHECK_EN
  logic q_ok, q_ok_d;
  logic tw_ok, tw_ok_d;
  logic tw_miss, tw_miss_d;
  logic err_d;

  assign start_ok = q_ok && tw_ok;

  always_comb begin
    q_ok_d    = q_ok;
    tw_ok_d   = tw_ok;
    tw_miss_d = tw_miss;
    err_d     = cmd_err;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_op == OP_START
            && !start_ok) begin
          err_d = 1'b1;
        end
      end
      ST_Q_HOLD: begin
        if (state_d == ST_IDLE) begin
          q_ok_d = 1'b1;
        end
      end
      ST_TW_ISSUE: begin
        tw_ok_d   = 1'b0;
        tw_miss_d = 1'b0;
      end
      ST_TW_STREAM: begin
        if (!tw_valid) begin
          tw_miss_d = 1'b1;
        end
        if (state_d == ST_IDLE) begin
          tw_ok_d = !tw_miss_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_ok    <= 1'b0;
      tw_ok   <= 1'b0;
      tw_miss <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      q_ok    <= q_ok_d;
      tw_ok   <= tw_ok_d;
      tw_miss <= tw_miss_d;
      cmd_err <= err_d;
    end
  end
`else
  assign start_ok = 1'b1;
`endif

endmodule
